dp_pipe: RTL and testbench

Parametrised, two-stage successor to the single-cycle datapath. It holds a resettable register file and an execute stage built on `eu_top`. Operations are issued through a valid/ready handshake, and memory loads complete through a req/ack handshake rather than in one cycle. It sits between the control unit, which issues micro-operations, and the memory interface.

---
 rtl/dp_pkg.sv | 30 +++
 rtl/dp_regfile.sv | 33 +++
 rtl/eu_top.sv | 32 +++
 rtl/dp_pipe.sv | 119 +++++++++++
 tb/tb_dp_pipe.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the two-stage datapath: EU operation codes and the
// width-independent control part of the execute register.
package dp_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_AND    = 4'h2,
    OP_OR     = 4'h3,
    OP_XOR    = 4'h4,
    OP_NOT    = 4'h5,
    OP_SHL    = 4'h6,
    OP_SHR    = 4'h7,
    OP_PASS_A = 4'h8,
    OP_PASS_B = 4'h9,
    OP_INC    = 4'hA,
    OP_DEC    = 4'hB
  } op_t;

  // Control fields of E; the parameter-width fields (a, b, rd) are attached by the top.
  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            md;
    logic [OP_W-1:0] op;
  } e_ctrl_t;

endpackage

// File: rtl/dp_regfile.sv
// Register file: two combinational read ports, one write port, all registers
// cleared by the asynchronous reset.
module dp_regfile #(
  parameter int BUS_WIDTH  = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [BUS_WIDTH-1:0]  wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [BUS_WIDTH-1:0]  rdata_a,
  output logic [BUS_WIDTH-1:0]  rdata_b
);

  localparam int NREG = 1 << REG_ADDR_W;

  logic [BUS_WIDTH-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/eu_top.sv
// Combinational execution unit; result is truncated to BUS_WIDTH.
module eu_top
  import dp_pkg::*;
#(
  parameter int BUS_WIDTH = 16
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic [OP_W-1:0]      op_select,
  output logic [BUS_WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op_t'(op_select))
      OP_ADD:    result = a + b;
      OP_SUB:    result = a - b;
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      OP_NOT:    result = ~a;
      OP_SHL:    result = {a[BUS_WIDTH-2:0], 1'b0};
      OP_SHR:    result = {1'b0, a[BUS_WIDTH-1:1]};
      OP_PASS_A: result = a;
      OP_PASS_B: result = b;
      OP_INC:    result = a + BUS_WIDTH'(1);
      OP_DEC:    result = a - BUS_WIDTH'(1);
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/dp_pipe.sv
// Two-stage datapath: issue/operand-fetch with write-back bypass, then an
// execute stage that retires ALU ops in one cycle and loads on mem_ack.
module dp_pipe
  import dp_pkg::*;
#(
  parameter int BUS_WIDTH   = 16,
  parameter int REG_ADDR_W  = 3,
  parameter int CONST_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic                   reg_write,
  input  logic [REG_ADDR_W-1:0]  rs_a,
  input  logic [REG_ADDR_W-1:0]  rs_b,
  input  logic [REG_ADDR_W-1:0]  rd,
  input  logic [CONST_WIDTH-1:0] constant_in,
  input  logic                   mb,
  input  logic                   md,
  input  logic [3:0]             op_select,
  output logic                   mem_req,
  input  logic                   mem_ack,
  input  logic [BUS_WIDTH-1:0]   data_in,
  output logic [BUS_WIDTH-1:0]   address_out,
  output logic [BUS_WIDTH-1:0]   data_out,
  output logic                   zero,
  output logic                   wb_valid,
  output logic [REG_ADDR_W-1:0]  wb_rd,
  output logic [BUS_WIDTH-1:0]   wb_data
);

  typedef struct packed {
    e_ctrl_t               ctrl;
    logic [REG_ADDR_W-1:0] rd;
    logic [BUS_WIDTH-1:0]  a;
    logic [BUS_WIDTH-1:0]  b;
  } e_reg_t;

  e_reg_t               e_reg;
  e_reg_t               e_next;
  logic                 zero_reg;
  logic                 done;
  logic                 issue_fire;
  logic [BUS_WIDTH-1:0] rf_a;
  logic [BUS_WIDTH-1:0] rf_b;
  logic [BUS_WIDTH-1:0] opnd_a;
  logic [BUS_WIDTH-1:0] opnd_b;
  logic [BUS_WIDTH-1:0] eu_result;

  dp_regfile #(
    .BUS_WIDTH (BUS_WIDTH),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_valid),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr_a(rs_a),
    .raddr_b(rs_b),
    .rdata_a(rf_a),
    .rdata_b(rf_b)
  );

  eu_top #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_eu (
    .a        (e_reg.a),
    .b        (e_reg.b),
    .op_select(e_reg.ctrl.op),
    .result   (eu_result)
  );

  // A load in E stalls issue until mem_ack; an ALU op always completes in its first E cycle.
  assign done        = e_reg.ctrl.valid && (!e_reg.ctrl.md || mem_ack);
  assign issue_ready = !e_reg.ctrl.valid || done;
  assign issue_fire  = issue_valid && issue_ready;

  // The retiring value is not yet in the register file, so forward it.
  assign opnd_a = (wb_valid && (wb_rd == rs_a)) ? wb_data : rf_a;
  assign opnd_b = mb ? BUS_WIDTH'(constant_in)
                     : ((wb_valid && (wb_rd == rs_b)) ? wb_data : rf_b);

  always_comb begin
    e_next = e_reg;
    if (issue_fire) begin
      e_next.ctrl.valid     = 1'b1;
      e_next.ctrl.reg_write = reg_write;
      e_next.ctrl.md        = md;
      e_next.ctrl.op        = op_select;
      e_next.rd             = rd;
      e_next.a              = opnd_a;
      e_next.b              = opnd_b;
    end else if (done) begin
      e_next.ctrl.valid = 1'b0;
    end
  end

  // IDLE/EXEC is e_reg.ctrl.valid; data fields are held after retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_reg    <= '0;
      zero_reg <= 1'b0;
    end else begin
      e_reg <= e_next;
      if (done && !e_reg.ctrl.md) zero_reg <= (eu_result == '0);
    end
  end

  assign mem_req     = e_reg.ctrl.valid && e_reg.ctrl.md;
  assign wb_valid    = done && e_reg.ctrl.reg_write;
  assign wb_rd       = e_reg.rd;
  assign wb_data     = e_reg.ctrl.md ? data_in : eu_result;
  assign address_out = e_reg.a;
  assign data_out    = e_reg.b;
  assign zero        = zero_reg;

endmodule

// File: tb/tb_dp_pipe.sv
// Self-checking bench for dp_pipe: directed scenarios plus randomized traffic
// against an architectural (in-order, sequential) reference model.
module tb_dp_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        iv, ir, wr, mbb, mdd, mreq, ack, zero, wbv;
  logic [2:0]  ra, rb, rdd, cst, wbrd;
  logic [3:0]  opsel;
  logic [15:0] din, addr, dout, wbdata;

  logic        w_iv, w_ir, w_wr, w_mb, w_md, w_mreq, w_ack, w_zero, w_wbv;
  logic [3:0]  w_ra, w_rb, w_rd, w_wbrd, w_op;
  logic [7:0]  w_cst;
  logic [31:0] w_din, w_addr, w_dout, w_wbdata;

  always #5 clk = ~clk;

  dp_pipe dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(iv), .issue_ready(ir), .reg_write(wr),
    .rs_a(ra), .rs_b(rb), .rd(rdd), .constant_in(cst), .mb(mbb), .md(mdd),
    .op_select(opsel), .mem_req(mreq), .mem_ack(ack), .data_in(din),
    .address_out(addr), .data_out(dout), .zero(zero), .wb_valid(wbv),
    .wb_rd(wbrd), .wb_data(wbdata)
  );

  dp_pipe #(.BUS_WIDTH(32), .REG_ADDR_W(4), .CONST_WIDTH(8)) dut_wide (
    .clk(clk), .rst_n(rst_n), .issue_valid(w_iv), .issue_ready(w_ir), .reg_write(w_wr),
    .rs_a(w_ra), .rs_b(w_rb), .rd(w_rd), .constant_in(w_cst), .mb(w_mb), .md(w_md),
    .op_select(w_op), .mem_req(w_mreq), .mem_ack(w_ack), .data_in(w_din),
    .address_out(w_addr), .data_out(w_dout), .zero(w_zero), .wb_valid(w_wbv),
    .wb_rd(w_wbrd), .wb_data(w_wbdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural reference: registers, zero flag and the one micro-op in flight.
  logic [15:0] m_regs [8];
  bit          m_valid, m_md, m_we, m_zero;
  logic [2:0]  m_rd;
  logic [15:0] m_a, m_b, m_res;

  logic        snap_ir, snap_mreq, snap_wbv, snap_zero;
  logic [2:0]  snap_wbrd;
  logic [15:0] snap_wbdata, snap_addr;

  function automatic logic [15:0] eu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~a;
      4'h6: return a << 1;
      4'h7: return a >> 1;
      4'h8: return a;
      4'h9: return b;
      4'hA: return a + 16'd1;
      4'hB: return a - 16'd1;
      default: return 16'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
    m_valid = 0; m_md = 0; m_we = 0; m_zero = 0;
  endtask

  task automatic drive(input bit v, input bit we, input logic [2:0] d, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] c, input bit imm, input bit mem,
                       input logic [3:0] op);
    iv = v; wr = we; rdd = d; ra = a; rb = b; cst = c; mbb = imm; mdd = mem; opsel = op;
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model.
  task automatic step();
    bit          exp_done, exp_ready, exp_wbv;
    logic [15:0] res;
    @(negedge clk);
    snap_ir = ir; snap_mreq = mreq; snap_wbv = wbv; snap_zero = zero;
    snap_wbrd = wbrd; snap_wbdata = wbdata; snap_addr = addr;
    exp_done  = m_valid && (!m_md || ack);
    exp_ready = !m_valid || exp_done;
    exp_wbv   = exp_done && m_we;
    check_eq("issue_ready", 32'(ir), 32'(exp_ready));
    check_eq("mem_req", 32'(mreq), 32'(m_valid && m_md));
    check_eq("zero", 32'(zero), 32'(m_zero));
    check_eq("wb_valid", 32'(wbv), 32'(exp_wbv));
    if (m_valid) begin
      check_eq("address_out", 32'(addr), 32'(m_a));
      check_eq("data_out", 32'(dout), 32'(m_b));
    end
    if (exp_wbv) begin
      res = m_md ? din : m_res;
      check_eq("wb_rd", 32'(wbrd), 32'(m_rd));
      check_eq("wb_data", 32'(wbdata), 32'(res));
      m_regs[m_rd] = res;
      $display("txn retire %s r%0d <= %04h", m_md ? "load" : "alu ", m_rd, res);
    end
    if (exp_done && !m_md) m_zero = (m_res == 16'd0);
    if (exp_done) m_valid = 0;
    if (iv && exp_ready) begin
      m_valid = 1; m_md = mdd; m_we = wr; m_rd = rdd;
      m_a   = m_regs[ra];
      m_b   = mbb ? {13'd0, cst} : m_regs[rb];
      m_res = eu_ref(opsel, m_a, m_b);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ack = 0; din = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    w_iv = 0; w_wr = 0; w_ra = 0; w_rb = 0; w_rd = 0; w_cst = 0; w_mb = 0; w_md = 0;
    w_op = 0; w_ack = 0; w_din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset values
    check_eq("rst_issue_ready", 32'(ir), 32'd1);
    check_eq("rst_mem_req", 32'(mreq), 32'd0);
    check_eq("rst_wb_valid", 32'(wbv), 32'd0);
    check_eq("rst_zero", 32'(zero), 32'd0);
    check_eq("rst_address_out", 32'(addr), 32'd0);
    check_eq("rst_data_out", 32'(dout), 32'd0);
    check_eq("rst_wb_data", 32'(wbdata), 32'd0);
    check_eq("rst_wb_rd", 32'(wbrd), 32'd0);
    check_eq("rst_wide_ready", 32'(w_ir), 32'd1);

    // Every register reads 0 after reset (seen on address_out/data_out)
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 3'(i), 3'(7 - i), 0, 0, 0, 4'h0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    step();
    check_eq("rf_clear_last", 32'(snap_addr), 32'd0);

    // Immediate ADD followed by a dependent ADD through the bypass
    drive(1, 1, 3'd1, 3'd0, 3'd0, 3'd5, 1, 0, 4'h0);
    step();
    drive(1, 1, 3'd2, 3'd1, 3'd1, 3'd0, 0, 0, 4'h0);
    step();
    check_eq("add_imm_wb", 32'(snap_wbdata), 32'd5);
    check_eq("add_no_stall", 32'(snap_ir), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    step();
    check_eq("add_bypass_wb", 32'(snap_wbdata), 32'd10);

    // Load into r3 with three wait cycles
    drive(1, 1, 3'd3, 3'd2, 3'd0, 3'd0, 0, 1, 4'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("load_wait_req", 32'(snap_mreq), 32'd1);
      check_eq("load_wait_ready", 32'(snap_ir), 32'd0);
      check_eq("load_wait_addr", 32'(snap_addr), 32'd10);
    end
    ack = 1; din = 16'hBEEF;
    step();
    check_eq("load_ack_req", 32'(snap_mreq), 32'd1);
    check_eq("load_wb_rd", 32'(snap_wbrd), 32'd3);
    check_eq("load_wb_data", 32'(snap_wbdata), 32'hBEEF);
    check_eq("load_zero_kept", 32'(snap_zero), 32'd0);
    ack = 0;
    step();

    // Zero flag: SUB r1-r1, then a load keeps it, then ADD const 1 clears it
    drive(1, 1, 3'd4, 3'd1, 3'd1, 3'd0, 0, 0, 4'h1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    step(); step();
    check_eq("zero_after_sub", 32'(snap_zero), 32'd1);
    drive(1, 1, 3'd5, 3'd0, 3'd0, 3'd0, 0, 1, 4'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    ack = 1; din = 16'h0042;
    step();
    ack = 0;
    step();
    check_eq("zero_after_load", 32'(snap_zero), 32'd1);
    drive(1, 1, 3'd6, 3'd0, 3'd0, 3'd1, 1, 0, 4'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    step(); step();
    check_eq("zero_after_add1", 32'(snap_zero), 32'd0);

    // Reset while a load waits for mem_ack
    drive(1, 1, 3'd7, 3'd1, 3'd0, 3'd0, 0, 1, 4'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    step();
    check_eq("rstload_req_before", 32'(snap_mreq), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("rstload_req_drop", 32'(mreq), 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ack = 1; din = 16'h1234;
    step();
    check_eq("rstload_no_wb", 32'(snap_wbv), 32'd0);
    ack = 0;
    drive(1, 0, 3'd0, 3'd7, 3'd7, 3'd0, 0, 0, 4'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    step();
    check_eq("rstload_r7_zero", 32'(snap_addr), 32'd0);

    // Randomized micro-op stream
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 9) < 8), 1'($urandom), 3'($urandom), 3'($urandom),
            3'($urandom), 3'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)));
      ack = ($urandom_range(0, 2) == 0);
      din = 16'($urandom);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    ack = 1;
    step();
    ack = 0;
    step();

    // Wide configuration: const 0xFF into r15, then read it back
    w_iv = 1; w_wr = 1; w_rd = 4'd15; w_ra = 4'd0; w_cst = 8'hFF; w_mb = 1; w_op = 4'h0;
    @(posedge clk); #1;
    w_iv = 0;
    @(negedge clk);
    check_eq("wide_wb_valid", 32'(w_wbv), 32'd1);
    check_eq("wide_wb_rd", 32'(w_wbrd), 32'd15);
    check_eq("wide_wb_data", w_wbdata, 32'h0000_00FF);
    $display("txn wide retire r15 <= %08h", w_wbdata);
    @(posedge clk); #1;
    w_iv = 1; w_wr = 0; w_ra = 4'd15; w_cst = 8'h00;
    @(posedge clk); #1;
    w_iv = 0;
    @(negedge clk);
    check_eq("wide_readback_addr", w_addr, 32'h0000_00FF);
    check_eq("wide_readback_res", w_wbdata, 32'h0000_00FF);
    check_eq("wide_readback_nowb", 32'(w_wbv), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
